// File: rtl/lockin_demodulator.sv
// ============================================================================
// lockin_demodulator
// ----------------------------------------------------------------------------
// Synchronous (lock-in) detector. Correlates a filtered signal with the
// sine/cosine reference over a programmed number of valid samples, after an
// optional settling interval, and reports the in-phase and quadrature sums.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lockin_demodulator #(
  parameter int word_width  = 16,
  parameter int count_width = 32,
  parameter int acc_width   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [count_width-1:0]       settle_count,
  input  logic [count_width-1:0]       sample_count,
  input  logic signed [word_width-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic signed [word_width-1:0] sin_ref,
  input  logic signed [word_width-1:0] cos_ref,
  output logic                         busy,
  output logic                         done,
  output logic signed [acc_width-1:0]  i_sum,
  output logic signed [acc_width-1:0]  q_sum,
  output logic                         overflow
);

  // Full-precision product width
  localparam int PW = 2 * word_width;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   drain_q;
  logic [count_width-1:0] settle_lim_q;
  logic [count_width-1:0] sample_lim_q;
  logic [count_width-1:0] settle_cnt_q;
  logic [count_width-1:0] sample_cnt_q;

  // Counter increments are one bit wider than the counters so that a limit of
  // 2^count_width-1 is reached without the count ever wrapping.
  logic [count_width:0]   settle_nxt_d;
  logic [count_width:0]   sample_nxt_d;

  assign settle_nxt_d = {1'b0, settle_cnt_q} + {{count_width{1'b0}}, 1'b1};
  assign sample_nxt_d = {1'b0, sample_cnt_q} + {{count_width{1'b0}}, 1'b1};

  // A measurement begins (and clears the result registers) on this cycle
  logic run_start_d;
  // A valid sample is taken into the multiply pipeline on this cycle
  logic sample_take_d;

  assign run_start_d   = (state_q == ST_IDLE) && start;
  assign sample_take_d = (state_q == ST_ACCUM) && sample_valid;

  // --------------------------------------------------------------------------
  // Datapath state
  // --------------------------------------------------------------------------
  logic                        prod_vld_q;
  logic signed [PW-1:0]        prod_i_q;
  logic signed [PW-1:0]        prod_q_q;
  logic signed [acc_width-1:0] acc_i_q;
  logic signed [acc_width-1:0] acc_q_q;
  logic                        ovf_q;

  logic signed [acc_width-1:0] ext_i_d;
  logic signed [acc_width-1:0] ext_q_d;
  logic signed [acc_width-1:0] acc_i_d;
  logic signed [acc_width-1:0] acc_q_d;
  logic                        ovf_i_d;
  logic                        ovf_q_d;

  // Measurement sequencer: settle, accumulate, drain the pipeline, report
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drain_q      <= 1'b0;
      settle_lim_q <= '0;
      sample_lim_q <= '0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            settle_lim_q <= settle_count;
            sample_lim_q <= sample_count;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            drain_q      <= 1'b0;
            busy_q       <= 1'b1;
            // Nothing to accumulate: settling is pointless, go straight to
            // the drain so the run still reports a zero result.
            if (sample_count == '0) begin
              state_q <= ST_DRAIN;
            end else if (settle_count == '0) begin
              state_q <= ST_ACCUM;
            end else begin
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (sample_valid) begin
            settle_cnt_q <= settle_nxt_d[count_width-1:0];
            if (settle_nxt_d == {1'b0, settle_lim_q}) begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (sample_valid) begin
            sample_cnt_q <= sample_nxt_d[count_width-1:0];
            if (sample_nxt_d == {1'b0, sample_lim_q}) begin
              drain_q <= 1'b0;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Two cycles cover the multiply and accumulate stages
          if (drain_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 1: register full-precision signed products with a valid flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_vld_q <= 1'b0;
      prod_i_q   <= '0;
      prod_q_q   <= '0;
    end else begin
      prod_vld_q <= sample_take_d;
      if (sample_take_d) begin
        prod_i_q <= PW'(sample_in) * PW'(sin_ref);
        prod_q_q <= PW'(sample_in) * PW'(cos_ref);
      end
    end
  end

  // Stage 2 arithmetic: sign-extend, wrap-around add, signed overflow detect
  always_comb begin
    ext_i_d = acc_width'(prod_i_q);
    ext_q_d = acc_width'(prod_q_q);
    acc_i_d = acc_i_q + ext_i_d;
    acc_q_d = acc_q_q + ext_q_d;
    ovf_i_d = (acc_i_q[acc_width-1] == ext_i_d[acc_width-1]) &&
              (acc_i_d[acc_width-1] != acc_i_q[acc_width-1]);
    ovf_q_d = (acc_q_q[acc_width-1] == ext_q_d[acc_width-1]) &&
              (acc_q_d[acc_width-1] != acc_q_q[acc_width-1]);
  end

  // Stage 2 registers: accumulators and sticky overflow, cleared per run
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      ovf_q   <= 1'b0;
    end else if (run_start_d) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      ovf_q   <= 1'b0;
    end else if (prod_vld_q) begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      ovf_q   <= ovf_q | ovf_i_d | ovf_q_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign i_sum    = acc_i_q;
  assign q_sum    = acc_q_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lockin_demodulator.sv
// ============================================================================
// tb_lockin_demodulator
// ----------------------------------------------------------------------------
// Self-checking bench for lockin_demodulator: a behavioural model tracks the
// expected outputs every cycle; directed cases pin literal results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lockin_demodulator;

  localparam int W  = 16;
  localparam int CW = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                start32;
  logic [CW-1:0]       settle_count;
  logic [CW-1:0]       sample_count;
  logic signed [W-1:0] sample_in;
  logic                sample_valid;
  logic signed [W-1:0] sin_ref;
  logic signed [W-1:0] cos_ref;

  logic                busy, done, overflow;
  logic signed [63:0]  i_sum, q_sum;
  logic                busy32, done32, overflow32;
  logic signed [31:0]  i_sum32, q_sum32;

  lockin_demodulator #(.word_width(W), .count_width(CW), .acc_width(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .settle_count(settle_count), .sample_count(sample_count),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sin_ref(sin_ref), .cos_ref(cos_ref),
    .busy(busy), .done(done), .i_sum(i_sum), .q_sum(q_sum),
    .overflow(overflow)
  );

  lockin_demodulator #(.word_width(W), .count_width(CW), .acc_width(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .settle_count(settle_count), .sample_count(sample_count),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sin_ref(sin_ref), .cos_ref(cos_ref),
    .busy(busy32), .done(done32), .i_sum(i_sum32), .q_sum(q_sum32),
    .overflow(overflow32)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct {
    longint pi;
    longint pq;
    int     vis;
  } contrib_t;

  contrib_t pend[$];
  int     cyc = 0;
  bit     chk_en = 1'b0;
  bit     m_run = 1'b0;
  int     m_done_cyc = -1;
  longint m_settle, m_count, m_seen;
  longint e_i = 0, e_q = 0;
  bit     e_busy = 1'b0, e_done = 1'b0;

  // Inputs seen at a rising edge belong to cycle 'cyc'; the model derives the
  // outputs of cycle cyc+1 from the measurement rules.
  always @(posedge clk) begin
    if (!rst) begin
      m_run      = 1'b0;
      m_done_cyc = -1;
      pend.delete();
      e_i = 0; e_q = 0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      if (!m_run && start) begin
        m_run    = 1'b1;
        m_settle = longint'(settle_count);
        m_count  = longint'(sample_count);
        m_seen   = 0;
        pend.delete();
        e_i = 0; e_q = 0;
        m_done_cyc = (sample_count == 0) ? cyc + 3 : 32'h7fffffff;
      end else if (m_run && sample_valid && (m_seen < m_settle + m_count)) begin
        m_seen++;
        if (m_seen > m_settle) begin
          pend.push_back('{longint'(sample_in) * longint'(sin_ref),
                           longint'(sample_in) * longint'(cos_ref), cyc + 2});
          if (m_seen == m_settle + m_count) m_done_cyc = cyc + 3;
        end
      end
      while (pend.size() > 0 && pend[0].vis == cyc + 1) begin
        e_i += pend[0].pi;
        e_q += pend[0].pq;
        void'(pend.pop_front());
      end
      e_done = m_run && (cyc + 1 == m_done_cyc);
      e_busy = m_run && (cyc + 1 <= m_done_cyc);
      if (m_run && (cyc + 1 > m_done_cyc)) m_run = 1'b0;
    end
    cyc++;
    chk_en = 1'b1;
  end

  // -------------------------------------------------------------- checking
  int vectors = 0;
  int miscompares = 0;

  task automatic compare_cycle();
    vectors++;
    if (busy !== e_busy || done !== e_done || overflow !== 1'b0 ||
        i_sum !== e_i || q_sum !== e_q) begin
      miscompares++;
      $display("FAIL cycle %0d: busy %b want %b, done %b want %b, ovf %b want 0, i %0d want %0d, q %0d want %0d",
               cyc, busy, e_busy, done, e_done, overflow, i_sum, e_i, q_sum, e_q);
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------- stimulus
  int sin_tab[16];
  int cos_tab[16];
  int sidx = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input update for the current cycle, by stimulus mode
  task automatic drive(input int mode);
    start32 = 1'b0;
    case (mode)
      1: begin
        sample_valid = ($urandom_range(0, 3) != 0);
        sample_in    = W'($urandom);
        sin_ref      = W'($urandom);
        cos_ref      = W'($urandom);
        start        = busy && ($urandom_range(0, 3) == 0);
      end
      2: begin
        start        = 1'b0;
        sample_valid = ~sample_valid;
        if (sample_valid) sample_in = sample_in + 16'sd1;
      end
      3, 4: begin
        start        = 1'b0;
        sidx         = (sidx + 1) % 16;
        sin_ref      = W'(sin_tab[sidx]);
        cos_ref      = W'(cos_tab[sidx]);
        sample_in    = (mode == 3) ? W'(sin_tab[sidx]) : W'(cos_tab[sidx]);
        sample_valid = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic wait_done(input bit sel32, input int mode, input int limit,
                           input bit clr, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if ((sel32 ? done32 : done) === 1'b1) begin
        at = cyc;
        if (clr) start = 1'b0;
        break;
      end
      drive(mode);
    end
    if (at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: no done within %0d cycles, got 0 want 1", limit);
    end
  endtask

  initial begin
    int     t0, at, at2, ndone;
    longint exp_big, diff;

    for (int k = 0; k < 16; k++) begin
      sin_tab[k] = $rtoi($floor(16384.0 * $sin(2.0 * 3.14159265358979 * k / 16.0) + 0.5));
      cos_tab[k] = $rtoi($floor(16384.0 * $cos(2.0 * 3.14159265358979 * k / 16.0) + 0.5));
    end

    rst = 1'b0; start = 1'b0; start32 = 1'b0;
    settle_count = '0; sample_count = '0;
    sample_in = '0; sample_valid = 1'b0; sin_ref = '0; cos_ref = '0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) compare_cycle();
      end
    join_none

    // Reset with random activity on the inputs
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1);
      start = $urandom_range(0, 1) == 1;
      settle_count = $urandom_range(0, 3);
      sample_count = $urandom_range(0, 3);
    end
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_i", i_sum, 0);
    chk("reset_q", q_sum, 0);
    chk("reset32_i", i_sum32, 0);
    chk("reset32_busy", busy32, 0);
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
    tick();

    // DC correlation, start held high through the run (must be ignored)
    sample_in = 16'sd1000; sin_ref = 16'sd2000; cos_ref = -16'sd3; sample_valid = 1'b1;
    settle_count = 0; sample_count = 10; start = 1'b1; t0 = cyc;
    wait_done(1'b0, 0, 40, 1'b1, at);
    chk("dc_done_latency", at - t0, 13);
    chk("dc_i", i_sum, 64'sd20000000);
    chk("dc_q", q_sum, -64'sd30000);
    chk("dc_ovf", overflow, 0);
    tick(); tick();

    // Settling with alternating valid
    settle_count = 4; sample_count = 3; sin_ref = 16'sd1; cos_ref = 16'sd1;
    sample_in = 16'sd0; sample_valid = 1'b0; start = 1'b1;
    wait_done(1'b0, 2, 60, 1'b1, at);
    chk("settle_i", i_sum, 18);
    chk("settle_q", q_sum, 18);
    sample_valid = 1'b0;
    tick(); tick();

    // Overflow on a 32-bit accumulator instance
    sample_in = -16'sd32768; sin_ref = -16'sd32768; cos_ref = -16'sd32768;
    sample_valid = 1'b1; settle_count = 0; sample_count = 3; start32 = 1'b1;
    wait_done(1'b1, 0, 40, 1'b1, at);
    chk("ovf32_i", longint'($unsigned(i_sum32)), 64'hC0000000);
    chk("ovf32_flag", overflow32, 1);
    sample_valid = 1'b0;
    tick(); tick();

    // Reset pulse in the middle of accumulation
    sample_in = 16'sd7; sin_ref = 16'sd5; cos_ref = -16'sd3; sample_valid = 1'b1;
    settle_count = 0; sample_count = 20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midreset_busy", busy, 0);
    chk("midreset_i", i_sum, 0);
    chk("midreset_q", q_sum, 0);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("midreset_no_done", ndone, 0);

    // Zero counts
    settle_count = 0; sample_count = 0; start = 1'b1; t0 = cyc;
    wait_done(1'b0, 0, 20, 1'b1, at);
    chk("zero_done_latency", at - t0, 3);
    chk("zero_i", i_sum, 0);
    tick(); tick();

    // Start held across DONE re-triggers on the first idle cycle
    sample_in = 16'sd3; sin_ref = 16'sd4; cos_ref = 16'sd5; sample_valid = 1'b1;
    settle_count = 0; sample_count = 2; start = 1'b1; t0 = cyc;
    wait_done(1'b0, 0, 40, 1'b0, at);
    chk("hold_done_latency", at - t0, 5);
    tick();
    tick();
    start = 1'b0;
    chk("hold_retrigger_busy", busy, 1);
    wait_done(1'b0, 0, 40, 1'b1, at2);
    chk("hold_second_done", at2 - at, 6);
    tick(); tick();

    // Sine loopback, sample = sine then sample = cosine
    exp_big = 64'sd160 * 64'sd16384 * 64'sd16384 / 2;
    for (int m = 3; m <= 4; m++) begin
      sidx = 0;
      sin_ref = W'(sin_tab[0]); cos_ref = W'(cos_tab[0]);
      sample_in = (m == 3) ? W'(sin_tab[0]) : W'(cos_tab[0]);
      sample_valid = 1'b1; settle_count = 0; sample_count = 160; start = 1'b1;
      wait_done(1'b0, m, 400, 1'b1, at);
      diff = ((m == 3) ? i_sum : q_sum) - exp_big;
      if (diff < 0) diff = -diff;
      vectors++;
      if (diff * 100 > exp_big) begin
        miscompares++;
        $display("FAIL sine_main_%0d: got %0d want %0d +-1%%", m, (m == 3) ? i_sum : q_sum, exp_big);
      end
      diff = (m == 3) ? q_sum : i_sum;
      if (diff < 0) diff = -diff;
      vectors++;
      if (diff * 100 >= exp_big) begin
        miscompares++;
        $display("FAIL sine_cross_%0d: got %0d want |x| < %0d", m, diff, exp_big / 100);
      end
      sample_valid = 1'b0;
      tick(); tick();
    end

    // Randomized runs with gaps and ignored starts while busy
    for (int r = 0; r < 25; r++) begin
      sample_count = $urandom_range(0, 24);
      settle_count = (sample_count == 0) ? 0 : $urandom_range(0, 5);
      drive(1);
      start = 1'b1;
      wait_done(1'b0, 1, 300, 1'b1, at);
      for (int k = 0; k < $urandom_range(1, 4); k++) begin
        tick();
        drive(1);
      end
    end
    start = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lockin_demodulator.md
# lockin_demodulator

Synchronous (lock-in) detector that receives a filtered signal together with the sine/cosine reference produced by `sine_gen` and measures in-phase and quadrature response. It correlates the signal with the reference over a programmed number of valid samples, after an optional settling interval, and reports the two accumulated sums. It sits downstream of `cascade_low_pass_filter` and provides the in-hardware measurement of the response to a `sine_gen` stimulus. Software derives gain and phase from the I/Q sums.

## Interface
Parameters:
- `word_width`, 16, width of sample and reference words (two's complement signed)
- `count_width`, 32, width of settle and sample counters
- `acc_width`, 64, width of I/Q accumulators (≥ 2*word_width)

Ports:
- `clk`  in  1  system clock (250 MHz domain)
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `start`  in  1  measurement request, sampled only in IDLE
- `settle_count`  in  count_width  valid samples to discard before accumulating; latched on start
- `sample_count`  in  count_width  valid samples to accumulate; latched on start
- `sample_in`  in  word_width  signed signal under test
- `sample_valid`  in  1  qualifies `sample_in`, `sin_ref`, `cos_ref`
- `sin_ref`  in  word_width  signed in-phase reference
- `cos_ref`  in  word_width  signed quadrature reference
- `busy`  out  1  high from the cycle after start acceptance until `done`
- `done`  out  1  one-cycle pulse; results valid from this cycle
- `i_sum`  out  acc_width  signed Σ sample_in*sin_ref
- `q_sum`  out  acc_width  signed Σ sample_in*cos_ref
- `overflow`  out  1  sticky per measurement; signed overflow occurred in either accumulator

## Operation
- States: IDLE, SETTLE, ACCUM, DRAIN, DONE.
- IDLE: When `start`=1, the block latches both counts, clears the accumulators, `overflow`, and the internal counters, and moves to SETTLE. If `settle_count`=0, it moves directly to ACCUM. If `sample_count`=0, it moves directly to DRAIN.
- SETTLE: Each `sample_valid` cycle increments the settle counter. Samples are not multiplied into the sums. When the counter reaches `settle_count`, the state moves to ACCUM. The sample that reaches the count is the last discarded sample.
- ACCUM: Each `sample_valid` cycle is accepted into the pipeline and increments the sample counter. After the `sample_count`-th accepted sample, the state moves to DRAIN. Samples with `sample_valid`=0 are ignored in every state.
- Pipeline:
  - Stage 1 registers the full-precision signed products `sample_in*sin_ref` and `sample_in*cos_ref` (2*word_width bits each) and a valid bit.
  - Stage 2 sign-extends each product to acc_width and adds it to its accumulator.
  - Accumulators wrap in two's complement; they do not saturate.
  - `overflow` is set when the operands of an add have the same sign and the result has the opposite sign.
- DRAIN: Waits 2 cycles so that the final product has been added, then moves to DONE.
- DONE: Pulses `done` for 1 cycle, deasserts `busy`, and returns to IDLE.
- `i_sum`, `q_sum`, and `overflow` hold their values in IDLE until the next accepted start. They update live during a run.
- `start` while not IDLE is ignored. `start` held high re-triggers one cycle after DONE, on the first IDLE cycle.
- Reset (`rst`=0) in any state, including mid-run:
  - next state is IDLE
  - `busy`=0, `done`=0, `overflow`=0
  - `i_sum`=0, `q_sum`=0
  - pipeline valid bits cleared

## Timing
- Start accepted at cycle T (IDLE, `start`=1) → `busy`=1 at T+1.
- The accepted sample at cycle S contributes to `i_sum`/`q_sum` visible at S+2.
- Last accepted sample at cycle L → state DRAIN at L+1, DONE at L+3 (`done`=1, `busy` falls at L+4).
  - All sums are final by L+2. Registered outputs are stable when `done` is high.
- `sample_count`=0, `settle_count`=0: `done` is asserted at T+3 with sums 0.
- Maximum throughput is one sample per cycle; there are no stall cycles.
- Counter limits: counts up to 2^count_width−1 are legal. Counters must not wrap before compare.

## Test plan
- Reset values: hold `rst`=0 for 5 cycles with random inputs → `busy`=0, `done`=0, `overflow`=0, `i_sum`=0, `q_sum`=0.
- DC correlation: `sample_in`=1000, `sin_ref`=2000, `cos_ref`=−3, `sample_valid`=1 continuously, `settle_count`=0, `sample_count`=10 → `i_sum`=20,000,000, `q_sum`=−30,000, `done` 13 cycles after start, `overflow`=0.
- Settling and gaps:
  - Stimulus: `settle_count`=4, `sample_count`=3; `sample_valid` toggles 1,0,1,0…; samples 1..7 (sin_ref=1, cos_ref=1).
  - Required response: `i_sum`=`q_sum`=5+6+7=18, counted only on valid cycles.
- Sine loopback: feed `sine_out`/`cosine_out` of `sine_gen` (period=2) as both sample and refs, with `sample_count`=1024*2*10:
  - sample = sine, refs = sine/cosine → `i_sum` ≈ N*A²/2 (±1 %), `|q_sum|` < 1 % of `i_sum`.
  - sample = cosine → the I/Q roles swap.
- Overflow: parameter `acc_width`=32; `sample_in`=`sin_ref`=−32768, 3 samples → `overflow`=1, `i_sum` wraps to 0xC0000000 = 3*2^30 mod 2^32 (−2^30 as signed).
- Reset mid-run and zero counts:
  - Pulse `rst`=0 in ACCUM → IDLE, sums 0, no `done`.
  - A following start with `sample_count`=0 → `done` at T+3, sums 0.
  - `start` asserted while busy → no second run.
